icache_refill_ctrl: RTL and testbench

//  Miss/refill sequencer for the direct-mapped L1 instruction cache (8 lines x 128 bit).

---
 rtl/icache_refill_ctrl.sv | 145 ++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss/refill sequencer for an 8-line x 128-bit direct-mapped I-cache.
// Build macro ICACHE_REFILL_TIMEOUT_EN adds a wait-cycle abort (TIMEOUT_CYC) reported on refill_err.
module icache_refill_ctrl #(
`ifdef ICACHE_REFILL_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 255,
`endif
    parameter int unsigned LINE_WORDS  = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         fetch_valid,
    input  logic [31:0]  fetch_addr,
    input  logic         cache_hit,
    output logic         cpu_stall,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         line_wr,
    output logic [31:0]  line_addr,
    output logic [127:0] line_data,
    output logic         refill_busy,
    output logic         refill_err,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        BEAT   = 3'd2,
        FILL   = 3'd3,
        SETTLE = 3'd4
    } state_t;

    localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

    state_t      state;
    logic [31:0] miss_addr;
    logic [1:0]  beat_cnt;

    // Memory handshake: mem_req stays high with mem_addr stable until a cycle where mem_ack=1
    // is sampled; afterwards every cycle with mem_rvalid=1 in BEAT is exactly one accepted beat.
    assign cpu_stall = (state != IDLE) | (fetch_valid & ~cache_hit);
    assign mem_addr  = miss_addr;
    assign state_dbg = state;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       wait_expired;

    assign wait_expired = ({24'd0, wait_cnt} >= (TIMEOUT_CYC - 1));
`else
    assign refill_err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            miss_addr   <= '0;
            beat_cnt    <= '0;
            mem_req     <= 1'b0;
            line_wr     <= 1'b0;
            line_addr   <= '0;
            line_data   <= '0;
            refill_busy <= 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
            wait_cnt    <= '0;
            refill_err  <= 1'b0;
`endif
        end else begin
            line_wr <= 1'b0;
`ifdef ICACHE_REFILL_TIMEOUT_EN
            refill_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (fetch_valid && !cache_hit) begin
                        miss_addr   <= fetch_addr & ~32'hF;
                        mem_req     <= 1'b1;
                        refill_busy <= 1'b1;
                        state       <= REQ;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end
                end
                REQ: begin
                    // Beats are not accepted here, even in the ack cycle itself.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= BEAT;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 8'd1;
                    end else if (wait_expired) begin
                        mem_req     <= 1'b0;
                        refill_busy <= 1'b0;
                        refill_err  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                BEAT: begin
                    if (mem_rvalid) begin
                        line_data[{beat_cnt, 5'd0} +: 32] <= mem_rdata;
                        beat_cnt <= beat_cnt + 2'd1;
`ifdef ICACHE_REFILL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (beat_cnt == LAST_BEAT) begin
                            line_wr   <= 1'b1;
                            line_addr <= miss_addr;
                            state     <= FILL;
                        end
`ifdef ICACHE_REFILL_TIMEOUT_EN
                    end else if (wait_expired) begin
                        refill_busy <= 1'b0;
                        refill_err  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end
                FILL: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    // Gives the cache one cycle to re-look up the freshly installed line.
                    refill_busy <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    mem_req     <= 1'b0;
                    refill_busy <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: vector table, randomized refills against a queue model, reset/timeout sequences.
module tb_icache_refill_ctrl;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         fetch_valid;
    logic [31:0]  fetch_addr;
    logic         cache_hit;
    logic         cpu_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         line_wr;
    logic [31:0]  line_addr;
    logic [127:0] line_data;
    logic         refill_busy;
    logic         refill_err;
    logic [2:0]   state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [127:0] exp_q[$];
    logic [31:0]  exp_addr_q[$];
    int           exp_cyc_q[$];

    typedef struct {
        logic [31:0]  addr;
        int           ack_dly;
        logic [15:0]  gaps;
        int           extra;
        logic [127:0] words;
        logic [31:0]  noise;
        logic [127:0] exp_line;
        logic [31:0]  exp_laddr;
    } vec_t;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    icache_refill_ctrl #(.TIMEOUT_CYC(8)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .cache_hit   (cache_hit),
        .cpu_stall   (cpu_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .line_wr     (line_wr),
        .line_addr   (line_addr),
        .line_data   (line_data),
        .refill_busy (refill_busy),
        .refill_err  (refill_err),
        .state_dbg   (state_dbg)
    );
`else
    icache_refill_ctrl dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .cache_hit   (cache_hit),
        .cpu_stall   (cpu_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .line_wr     (line_wr),
        .line_addr   (line_addr),
        .line_data   (line_data),
        .refill_busy (refill_busy),
        .refill_err  (refill_err),
        .state_dbg   (state_dbg)
    );
`endif

    // Clock and cycle counter
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_mem_req"},     mem_req, 0);
        check({tag, "_mem_addr"},    mem_addr, 0);
        check({tag, "_line_wr"},     line_wr, 0);
        check({tag, "_line_addr"},   line_addr, 0);
        check({tag, "_line_data"},   line_data, 0);
        check({tag, "_refill_busy"}, refill_busy, 0);
        check({tag, "_refill_err"},  refill_err, 0);
        check({tag, "_cpu_stall"},   cpu_stall, 0);
    endtask

    // Scoreboard: every line_wr must match the oldest expected refill, in content and cycle
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && line_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_line_wr", line_wr, 0);
            end else begin
                check("line_data", line_data, exp_q.pop_front());
                check("line_addr", line_addr, exp_addr_q.pop_front());
                check("line_wr_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // One complete refill: miss, ack after ack_dly idle cycles, four beats with gaps, extra beats
    task automatic run_refill(input logic [31:0] addr, input int ack_dly, input logic [15:0] gaps,
                              input int extra, input logic [127:0] words, input logic [31:0] noise,
                              input logic [127:0] exp_line, input logic [31:0] exp_laddr);
        int gsum;
        int n;
        int c0;
        gsum = 0;
        for (int k = 0; k < 4; k++) gsum += int'(gaps[4*k +: 4]);
        @(negedge Clk);
        fetch_valid = 1'b1;
        cache_hit   = 1'b0;
        fetch_addr  = addr;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        #1 check("stall_on_miss", cpu_stall, 1);
        @(negedge Clk);
        c0 = cyc;
        exp_q.push_back(exp_line);
        exp_addr_q.push_back(exp_laddr);
        exp_cyc_q.push_back(c0 + 5 + ack_dly + gsum);
        fetch_addr = noise;
        for (int i = 0; i <= ack_dly; i++) begin
            check("req_mem_req", mem_req, 1);
            check("req_mem_addr", mem_addr, exp_laddr);
            check("req_stall", cpu_stall, 1);
            mem_ack    = (i == ack_dly);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            @(negedge Clk);
        end
        mem_ack = 1'b0;
        check("req_dropped", mem_req, 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                check("beat_stall", cpu_stall, 1);
                @(negedge Clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = words[32*k +: 32];
            @(negedge Clk);
        end
        for (int e = 0; e < extra; e++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(negedge Clk);
        end
        mem_rvalid  = 1'b0;
        fetch_valid = 1'b1;
        cache_hit   = 1'b1;
        n = 0;
        while (refill_busy && n < 20) begin
            check("settle_stall", cpu_stall, 1);
            @(negedge Clk);
            n++;
        end
        check("idle_cycle", cyc, c0 + 7 + ack_dly + gsum);
        #1 check("hit_releases_stall", cpu_stall, 0);
        check("line_data_hold", line_data, exp_line);
        check("line_addr_hold", line_addr, exp_laddr);
        check("scoreboard_drained", exp_q.size(), 0);
        fetch_valid = 1'b0;
        cache_hit   = 1'b0;
    endtask

    task automatic reset_mid_beat();
        @(negedge Clk);
        fetch_valid = 1'b1;
        cache_hit   = 1'b0;
        fetch_addr  = 32'h0000_0340;
        @(negedge Clk);
        fetch_valid = 1'b0;
        mem_ack     = 1'b1;
        @(negedge Clk);
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hAAAA_0001;
        @(negedge Clk);
        mem_rdata  = 32'hAAAA_0002;
        @(negedge Clk);
        check("beat_busy", refill_busy, 1);
        #1 Rst_n = 1'b0;
        #1 check_reset_zero("mid_beat");
        mem_rvalid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            check("post_reset_no_wr", line_wr, 0);
            check("post_reset_idle", refill_busy, 0);
        end
    endtask

    task automatic no_ack_sequence();
        @(negedge Clk);
        fetch_valid = 1'b1;
        cache_hit   = 1'b0;
        fetch_addr  = 32'h0000_0BB8;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        @(negedge Clk);
        fetch_valid = 1'b0;
        for (int rel = 0; rel < 14; rel++) begin
            check("no_ack_line_wr", line_wr, 0);
`ifdef ICACHE_REFILL_TIMEOUT_EN
            check("timeout_err", refill_err, rel == 8);
            check("timeout_req", mem_req, rel < 8);
            check("timeout_busy", refill_busy, rel < 8);
`else
            check("wait_err", refill_err, 0);
            check("wait_req", mem_req, 1);
            check("wait_addr", mem_addr, 32'h0000_0BB0);
            check("wait_stall", cpu_stall, 1);
`endif
            @(negedge Clk);
        end
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[5];
        logic [31:0]  beat_q[$];
        logic [31:0]  addr;
        logic [15:0]  gaps;
        logic [127:0] words;
        logic [127:0] m_line;
        logic [31:0]  m_laddr;

        vecs[0] = '{32'h0000_0124, 0, 16'h0000, 0,
                    128'h00000044_00000033_00000022_00000011, 32'h0000_0124,
                    128'h00000044_00000033_00000022_00000011, 32'h0000_0120};
        vecs[1] = '{32'h0000_0124, 3, 16'h1201, 0,
                    128'h00000044_00000033_00000022_00000011, 32'h0000_0124,
                    128'h00000044_00000033_00000022_00000011, 32'h0000_0120};
        vecs[2] = '{32'h0000_0124, 1, 16'h0000, 2,
                    128'h0F0F0F0F_89ABCDEF_01234567_DEADBEEF, 32'h0000_0200,
                    128'h0F0F0F0F_89ABCDEF_01234567_DEADBEEF, 32'h0000_0120};
        vecs[3] = '{32'hFFFF_FFFF, 2, 16'h0030, 1,
                    128'h00000004_00000003_00000002_00000001, 32'h0000_0000,
                    128'h00000004_00000003_00000002_00000001, 32'hFFFF_FFF0};
        vecs[4] = '{32'h0000_0000, 0, 16'h2222, 0,
                    128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hFFFF_FFFF,
                    128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0000_0000};

        Rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        cache_hit   = 1'b0;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        repeat (2) @(negedge Clk);
        check_reset_zero("reset");
        Rst_n = 1'b1;

        // Hit in IDLE never stalls nor requests memory
        @(negedge Clk);
        fetch_valid = 1'b1;
        cache_hit   = 1'b1;
        fetch_addr  = 32'h0000_0124;
        #1 check("hit_no_stall", cpu_stall, 0);
        repeat (4) begin
            @(negedge Clk);
            check("hit_no_req", mem_req, 0);
            check("hit_not_busy", refill_busy, 0);
        end
        fetch_valid = 1'b0;
        cache_hit   = 1'b0;

        for (int i = 0; i < 5; i++)
            run_refill(vecs[i].addr, vecs[i].ack_dly, vecs[i].gaps, vecs[i].extra,
                       vecs[i].words, vecs[i].noise, vecs[i].exp_line, vecs[i].exp_laddr);

        // Randomized refills: the line is the first four beats in arrival order
        for (int t = 0; t < 40; t++) begin
            addr = $urandom;
            for (int k = 0; k < 4; k++) gaps[4*k +: 4] = 4'($urandom_range(0, 2));
            beat_q.delete();
            for (int k = 0; k < 4; k++) beat_q.push_back($urandom);
            words   = {beat_q[3], beat_q[2], beat_q[1], beat_q[0]};
            m_line  = '0;
            for (int k = 0; k < 4; k++) m_line = m_line | ({96'd0, beat_q[k]} << (32 * k));
            m_laddr = addr - (addr % 32'd16);
            run_refill(addr, $urandom_range(0, 4), gaps, $urandom_range(0, 2),
                       words, $urandom, m_line, m_laddr);
        end

        reset_mid_beat();
        no_ack_sequence();

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
